// File: rtl/mult_seq_sn_pkg.sv
// mult_pkg: shared FSM state encoding and legal operand-width range for mult_seq_sn
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;
  localparam int N_MIN = 2;
  localparam int N_MAX = 32;
endpackage

// File: rtl/mult_seq_sn_if.sv
// mult_seq_sn_if: start/operand request and result/status bundle for mult_seq_sn
interface mult_seq_sn_if #(parameter int N = 16);
  logic           start;
  logic           sgn;
  logic [N-1:0]   ain;
  logic [N-1:0]   bin;
  logic [2*N-1:0] yout;
  logic           done;
  logic           valid;
  modport master (output start, sgn, ain, bin, input yout, done, valid);
  modport slave (input start, sgn, ain, bin, output yout, done, valid);
endinterface

// File: rtl/mult_seq_sn_twos_abs.sv
// twos_abs: magnitude of x, treating it as two's complement only when en is set
module twos_abs #(parameter int W = 16) (
  input  logic [W-1:0] x,
  input  logic         en,
  output logic [W-1:0] mag
);
  assign mag = (en & x[W-1]) ? -x : x;
endmodule

// File: rtl/mult_seq_sn.sv
// mult_seq_sn: sequential shift-add multiplier, signed/unsigned, early exit on zero multiplier
module mult_seq_sn
  import mult_pkg::*;
#(parameter int N = 16) (
  input logic          clk,
  input logic          resetb,
  mult_seq_sn_if.slave bus
);
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("mult_seq_sn: N out of range");
  end
  state_e         state_q;
  logic [2*N-1:0] a_q, acc_q, yout_q, acc_d, yout_d;
  logic [N-1:0]   b_q, a_mag, b_mag;
  logic           neg_q, done_q, valid_q;
  twos_abs #(.W(N)) u_abs_a (.x(bus.ain), .en(bus.sgn), .mag(a_mag));
  twos_abs #(.W(N)) u_abs_b (.x(bus.bin), .en(bus.sgn), .mag(b_mag));
  assign acc_d  = b_q[0] ? acc_q + a_q : acc_q;
  assign yout_d = neg_q ? -acc_q : acc_q;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      yout_q  <= '0;
      done_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= {{N{1'b0}}, a_mag};
          b_q     <= b_mag;
          acc_q   <= '0;
          neg_q   <= bus.sgn & (bus.ain[N-1] ^ bus.bin[N-1]);
          done_q  <= 1'b0;
          state_q <= RUN;
        end
        // the loop ends once the multiplier magnitude is exhausted
        RUN: if (b_q != '0) begin
          acc_q <= acc_d;
          b_q   <= b_q >> 1;
          a_q   <= a_q << 1;
        end else state_q <= FIX;
        FIX: begin
          yout_q  <= yout_d;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.yout  = yout_q;
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
endmodule

// File: doc/mult_seq_sn.md
# mult_seq_sn

Parametrised sequential shift-add multiplier that is the next generation of the team's 16-bit unsigned multiplier. It adds a width parameter, a per-operation signed/unsigned mode, a one-cycle `valid` completion pulse, and early termination on a zero multiplier. Start requests are ignored while an operation runs, and the previous result stays stable until the next completion. It serves as the low-area multiply engine for control-path arithmetic where multi-cycle latency is acceptable.

## Interface
- `N`, 16, operand width in bits; legal range 2..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply; sampled only while `done`=1.
- `sgn` in 1: mode, sampled with `start`; 1 = two's-complement operands, 0 = unsigned.
- `ain` in N: multiplicand, sampled with `start`.
- `bin` in N: multiplier, sampled with `start`.
- `yout` out 2N: product; updated only at completion.
- `done` out 1: 1 = idle and ready to accept `start`.
- `valid` out 1: one-cycle pulse marking the first cycle in which a new `yout` is visible.

## Operation
- States: IDLE, RUN, FIX.
- Internal registers:
  - `a` (2N-bit magnitude of the multiplicand, shifted left).
  - `b` (N-bit magnitude of the multiplier, shifted right).
  - `acc` (2N-bit running sum).
  - `neg` (1-bit result sign).
- Reset values:
  - `yout`=0, `done`=1, `valid`=0, state IDLE.
  - `a`, `b`, `acc`, `neg` = 0.
- IDLE, with `start`=1:
  - Capture `a`=|ain| zero-extended to 2N bits, and `b`=|bin|.
  - Clear `acc`.
  - Set `neg` = `sgn` & (ain[N-1] ^ bin[N-1]).
  - Set `done`=0 and go to RUN.
  - With `sgn`=0, magnitudes are the raw operands.
- IDLE, with `start`=0: hold all registers.
- RUN, when `b`≠0:
  - If b[0], `acc` += `a` (mod 2^2N; overflow is impossible by construction).
  - `b` >>= 1 and `a` <<= 1.
- RUN, when `b`=0: go to FIX with no arithmetic that cycle.
- FIX:
  - `yout` = `neg` ? (−`acc` mod 2^2N) : `acc`.
  - `done`=1, `valid`=1, go to IDLE.
- `valid` is cleared on every other edge, so it is high for exactly one cycle.
- `start` while `done`=0 is ignored. There is no restart and no error flag, and the ignored `sgn`/`ain`/`bin` have no effect.
- `yout` holds its previous value for the whole of RUN and FIX.
- Signed corner case, ain or bin = −2^(N−1):
  - The magnitude 2^(N−1) fits in N unsigned bits.
  - The product −2^(N−1)·−2^(N−1) = 2^(2N−2) is representable as positive in 2N bits.
- Zero operand: `bin`=0 goes straight RUN→FIX. `ain`=0 runs the full bit-length of |bin| and yields `acc`=0, then `yout`=0 with `neg` ignored (−0 = 0).

## Timing
- Let E0 be the edge that samples `start` in IDLE, and k = bit-length of |bin| (0 if zero, N max).
- Edges E1..Ek perform the shift-add steps.
- Edge E(k+1) detects `b`=0 and moves to FIX.
- Edge E(k+2) writes `yout` and sets `done` and `valid`.
- Latency:
  - Minimum 2 cycles, when `bin`=0.
  - Maximum N+2 cycles.
  - Latency is independent of `ain`.
- Back-to-back: `start` may be high in the same cycle `valid` is high. That edge is E0 of the next operation, so `done` is high for exactly one cycle.
- `resetb` low at any time, including mid-RUN or mid-FIX:
  - All registers return to reset values immediately.
  - The in-flight result is discarded and no `valid` pulse is emitted.
  - The first `start` after deassertion is accepted on the first rising edge.

## Structure
- Package `mult_pkg`:
  - State enum (IDLE, RUN, FIX) in a 2-bit encoding.
  - Localparams for the legal `N` range; instantiation with `N` outside 2..32 fails elaboration.
- One sub-module, `twos_abs`:
  - Parametrised width W.
  - Inputs: `x`, `en`. Output: `mag` = (`en` & x[W−1]) ? −x : x.
  - Instantiated twice (for `ain` and `bin`).
- The final negation is done inline with 2N-bit two's-complement arithmetic.

## Test plan
- Reset, then unsigned 0xFFFF × 0xFFFF with `sgn`=0 → `yout`=0xFFFE0001; `valid` at E18; `done` low for 18 cycles.
- Signed −3 × 7 (0xFFFD, 0x0007) with `sgn`=1 → `yout`=0xFFFFFFEB at E5.
- Signed 0x8000 × 0x8000 with `sgn`=1 → `yout`=0x40000000. Then the same operands with `sgn`=0 → 0x40000000, with latency N+2=18 in both cases.
- `bin`=0, `ain`=0x1234 → `yout`=0 at E2. Next: `ain`=0, `bin`=0x8001 with `sgn`=1 → `yout`=0.
- `start` pulsed with new operands at E3 of a running 5×5 → ignored; `yout`=25; `yout` holds its old value until completion. Then `start` held high through `valid` → back-to-back accept with `done` high for one cycle.
- `resetb` asserted mid-RUN → `yout`=0, `done`=1, no `valid` pulse. Then 2×3 → `yout`=6 at E4.
